bayer_window_gray_filter: RTL and testbench



---
 rtl/bayer_pkg.sv | 31 +++
 rtl/bayer_window_gray_filter_line_buffer_ram.sv | 38 +++
 rtl/bayer_window_gray_filter.sv | 142 ++++++++++++++
 tb/tb_bayer_window_gray_filter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_pkg.sv
// ============================================================================
// bayer_pkg : shared types and arithmetic helpers for the Bayer gray filter
// Rev 1.0
// ============================================================================
`default_nettype none

package bayer_pkg;

  typedef enum logic {
    MODE_AVG4  = 1'b0,
    MODE_GREEN = 1'b1
  } mode_e;

  // Four RAW_W-bit samples summed (or two doubled) never exceed RAW_W+2 bits.
  function automatic int SUM_W(input int raw_w);
    return raw_w + 2;
  endfunction

  function automatic logic [31:0] sat_shift(input logic [31:0] sum,
                                            input int          shift,
                                            input int          gray_w);
    logic [31:0] shifted;
    logic [31:0] max_val;
    shifted = sum >> shift;
    max_val = (32'd1 << gray_w) - 32'd1;
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bayer_window_gray_filter_line_buffer_ram.sv
// ============================================================================
// line_buffer_ram : one-line circular store, registered enable-gated read
// Rev 1.0
// ============================================================================
`default_nettype none

module line_buffer_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Reads return the old contents when addresses collide; no reset so the
  // array stays a plain block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/bayer_window_gray_filter.sv
// ============================================================================
// bayer_window_gray_filter : 2x2 Bayer window to grayscale, valid/SOF aware
// Rev 1.0
// ============================================================================
`default_nettype none

module bayer_window_gray_filter
  import bayer_pkg::*;
#(
  parameter int RAW_W       = 10,
  parameter int GRAY_W      = 8,
  parameter int LINE_LEN    = 640,
  parameter int SHIFT       = 6,
  parameter int GREEN_PHASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [RAW_W-1:0]  in_data,
  input  logic              mode,
  output logic              out_valid,
  output logic              out_sof,
  output logic [GRAY_W-1:0] out_data
);

  localparam int              SW     = SUM_W(RAW_W);
  localparam int              XW     = $clog2(LINE_LEN);
  localparam logic [XW-1:0]   X_LAST = XW'(LINE_LEN - 1);
  localparam logic [XW-1:0]   X_ONE  = XW'(1);
  localparam logic            GP     = 1'(GREEN_PHASE % 2);

  logic [XW-1:0]     x_q, x_d, x_eff;
  logic              row_ok_q, row_ok_d, row_ok_eff;
  logic              rowpar_q, rowpar_d, rowpar_eff;
  logic              locked_q, locked_d;
  logic              sof_pend_q, sof_pend_d;
  logic [RAW_W-1:0]  left_q, left_d;
  logic [RAW_W-1:0]  up_prev_q, up_prev_d;
  logic [RAW_W-1:0]  up;
  logic              take, wrap, win_valid, green_site;
  logic [SW-1:0]     sum;
  logic              out_valid_q, out_valid_d;
  logic              out_sof_q, out_sof_d;
  logic [GRAY_W-1:0] out_data_q, out_data_d;

  always_comb begin
    x_d        = x_q;
    row_ok_d   = row_ok_q;
    rowpar_d   = rowpar_q;
    locked_d   = locked_q;
    sof_pend_d = sof_pend_q;
    left_d     = left_q;
    up_prev_d  = up_prev_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_data_d  = out_data_q;

    // A start-of-frame pixel is always (0,0) regardless of where we were.
    take       = in_valid && (in_sof || locked_q);
    x_eff      = in_sof ? '0 : x_q;
    row_ok_eff = in_sof ? 1'b0 : row_ok_q;
    rowpar_eff = in_sof ? 1'b0 : rowpar_q;
    wrap       = (x_eff == X_LAST);
    green_site = ((x_eff[0] ^ rowpar_eff) == GP);
    win_valid  = take && row_ok_eff && (x_eff != '0);

    case (mode_e'(mode))
      MODE_GREEN: begin
        if (green_site) begin
          sum = (SW'(in_data) + SW'(up_prev_q)) << 1;
        end else begin
          sum = (SW'(left_q) + SW'(up)) << 1;
        end
      end
      default: sum = SW'(up_prev_q) + SW'(up) + SW'(left_q) + SW'(in_data);
    endcase

    if (take) begin
      x_d         = wrap ? '0 : x_eff + X_ONE;
      row_ok_d    = row_ok_eff | wrap;
      rowpar_d    = rowpar_eff ^ wrap;
      locked_d    = 1'b1;
      left_d      = in_data;
      up_prev_d   = up;
      out_valid_d = win_valid;
      out_sof_d   = win_valid && sof_pend_q && (x_eff == X_ONE);
      sof_pend_d  = in_sof | (sof_pend_q & ~out_sof_d);
      if (win_valid) begin
        out_data_d = GRAY_W'(sat_shift(32'(sum), SHIFT, GRAY_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      row_ok_q    <= 1'b0;
      rowpar_q    <= 1'b0;
      locked_q    <= 1'b0;
      sof_pend_q  <= 1'b0;
      left_q      <= '0;
      up_prev_q   <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      x_q         <= x_d;
      row_ok_q    <= row_ok_d;
      rowpar_q    <= rowpar_d;
      locked_q    <= locked_d;
      sof_pend_q  <= sof_pend_d;
      left_q      <= left_d;
      up_prev_q   <= up_prev_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_data_q  <= out_data_d;
    end
  end

  // The read is issued one pixel ahead (at the next x) so the registered
  // RAM output already holds the pixel above when that pixel arrives.
  line_buffer_ram #(
    .DEPTH (LINE_LEN),
    .WIDTH (RAW_W)
  ) u_line_buffer (
    .clk       (clk),
    .wr_en_i   (take && !reset),
    .wr_addr_i (x_eff),
    .wr_data_i (in_data),
    .rd_en_i   (take && !reset),
    .rd_addr_i (x_d),
    .rd_data_o (up)
  );

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_bayer_window_gray_filter.sv
// ============================================================================
// tb_bayer_window_gray_filter : scoreboard bench, SHIFT=2 and SHIFT=6 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bayer_window_gray_filter;

  localparam int L  = 8;
  localparam int GP = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [9:0] in_data = '0;
  logic       mode = 1'b0;
  logic       a_valid, a_sof, b_valid, b_sof;
  logic [7:0] a_data, b_data;

  always #5 clk = ~clk;

  bayer_window_gray_filter #(
    .RAW_W(10), .GRAY_W(8), .LINE_LEN(L), .SHIFT(2), .GREEN_PHASE(GP)
  ) u_dut_s2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .mode(mode),
    .out_valid(a_valid), .out_sof(a_sof), .out_data(a_data)
  );

  bayer_window_gray_filter #(
    .RAW_W(10), .GRAY_W(8), .LINE_LEN(L), .SHIFT(6), .GREEN_PHASE(GP)
  ) u_dut_s6 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .mode(mode),
    .out_valid(b_valid), .out_sof(b_sof), .out_data(b_data)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sof;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_valid = 1'b0;

  // Reference image model: full previous line kept as an array, y as an int.
  logic m_locked = 1'b0;
  int   m_x = 0;
  int   m_y = 0;
  int   m_prev[L];
  int   m_cur[L];

  function automatic logic [7:0] sat(input int s, input int sh);
    int v;
    v = s >> sh;
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_x = 0;
    m_y = 0;
  endtask

  task automatic model_pixel(input logic s, input int d, input logic m, output logic has);
    int   ul, u, l, sum;
    exp_t e;
    has = 1'b0;
    if (s) begin
      m_locked = 1'b1;
      m_x = 0;
      m_y = 0;
    end
    if (m_locked) begin
      m_cur[m_x] = d;
      if (m_y >= 1 && m_x >= 1) begin
        ul = m_prev[m_x-1];
        u  = m_prev[m_x];
        l  = m_cur[m_x-1];
        if (!m)                         sum = ul + u + l + d;
        else if (((m_x + m_y) % 2) == GP) sum = 2 * (d + ul);
        else                            sum = 2 * (l + u);
        e.a   = sat(sum, 2);
        e.b   = sat(sum, 6);
        e.sof = (m_y == 1) && (m_x == 1);
        exp_q.push_back(e);
        has = 1'b1;
      end
      m_x++;
      if (m_x == L) begin
        m_x = 0;
        m_y++;
        m_prev = m_cur;
      end
    end
  endtask

  task automatic drive(input logic v, input logic s, input int d, input logic m, input logic r);
    logic has;
    reset    = r;
    in_valid = v;
    in_sof   = s;
    in_data  = 10'(d);
    mode     = m;
    has      = 1'b0;
    if (r) model_reset();
    else if (v) model_pixel(s, d, m, has);
    @(posedge clk);
    #1;
    exp_valid = has;
  endtask

  always @(negedge clk) begin
    exp_t e;
    n_checks++;
    if (a_valid !== exp_valid || b_valid !== exp_valid) begin
      n_errors++;
      $display("FAIL out_valid got s2=%b s6=%b want %b at %0t", a_valid, b_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard got empty queue want entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (a_data !== e.a || b_data !== e.b || a_sof !== e.sof || b_sof !== e.sof) begin
          n_errors++;
          $display("FAIL pixel got s2=%0d s6=%0d sof=%b/%b want s2=%0d s6=%0d sof=%b at %0t",
                   a_data, b_data, a_sof, b_sof, e.a, e.b, e.sof, $time);
        end
      end
    end else begin
      n_checks++;
      if (a_sof !== 1'b0 || b_sof !== 1'b0) begin
        n_errors++;
        $display("FAIL out_sof_idle got %b/%b want 0 at %0t", a_sof, b_sof, $time);
      end
    end
  end

  task automatic test_reset();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 5, 1'b0, 1'b1);
    n_checks++;
    if (a_valid !== 1'b0 || a_sof !== 1'b0 || a_data !== 8'd0 ||
        b_valid !== 1'b0 || b_sof !== 1'b0 || b_data !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_state got v=%b s=%b d=%0d want 0 0 0", a_valid, a_sof, a_data);
    end
  endtask

  task automatic test_no_sof();
    for (int i = 0; i < L + 2; i++) begin
      drive(1'b1, 1'b0, 100, 1'b0, 1'b0);
      n_checks++;
      if (a_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL unlocked_output got %b want 0 (pixel %0d)", a_valid, i);
      end
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 2 * L; i++) begin
      drive(1'b1, i == 0, 8 + i, 1'b0, 1'b0);
      if (i == L + 1) begin
        // window (8,9,16,17): sum 50 -> 12 with SHIFT=2, 0 with SHIFT=6
        n_checks++;
        if (a_valid !== 1'b1 || a_sof !== 1'b1 || a_data !== 8'd12 || b_data !== 8'd0) begin
          n_errors++;
          $display("FAIL ramp_first got v=%b sof=%b s2=%0d s6=%0d want 1 1 12 0",
                   a_valid, a_sof, a_data, b_data);
        end
      end
    end
  endtask

  task automatic test_flat(input int val, input logic [7:0] want_a, input logic [7:0] want_b);
    for (int i = 0; i < 2 * L; i++) begin
      drive(1'b1, i == 0, val, 1'b0, 1'b0);
      if (i == L + 1) begin
        n_checks++;
        if (a_data !== want_a || b_data !== want_b || a_valid !== 1'b1) begin
          n_errors++;
          $display("FAIL flat_%0d got s2=%0d s6=%0d want %0d %0d", val, a_data, b_data, want_a, want_b);
        end
      end
    end
  endtask

  task automatic test_green();
    int x, y;
    for (int i = 0; i < 3 * L; i++) begin
      x = i % L;
      y = i / L;
      drive(1'b1, i == 0, (((x + y) % 2) == GP) ? 200 : 0, 1'b1, 1'b0);
      if (x == 0 && y >= 1) begin
        n_checks++;
        if (a_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL green_x0 got %b want 0 (row %0d)", a_valid, y);
        end
      end else if (y >= 1) begin
        n_checks++;
        if (a_valid !== 1'b1 || a_data !== 8'd200 || b_data !== 8'd12) begin
          n_errors++;
          $display("FAIL green_val got v=%b s2=%0d s6=%0d want 1 200 12", a_valid, a_data, b_data);
        end
      end
    end
  endtask

  task automatic test_stall();
    int   sd[3*L];
    logic sm[3*L];
    for (int i = 0; i < 3 * L; i++) begin
      sd[i] = int'($urandom_range(1023));
      sm[i] = 1'($urandom_range(1));
    end
    for (int i = 0; i < 3 * L; i++) drive(1'b1, i == 0, sd[i], sm[i], 1'b0);
    for (int i = 0; i < 3 * L; i++) begin
      if ($urandom_range(2) == 0) begin
        for (int k = 0; k <= int'($urandom_range(1)); k++) begin
          drive(1'b0, 1'($urandom_range(1)), int'($urandom_range(1023)), 1'($urandom_range(1)), 1'b0);
          n_checks++;
          if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_valid got %b/%b want 0", a_valid, b_valid);
          end
        end
      end
      drive(1'b1, i == 0, sd[i], sm[i], 1'b0);
    end
  endtask

  task automatic test_midline_sof();
    logic seen;
    for (int i = 0; i < 2 * L + 4; i++) drive(1'b1, i == 0, (i * 37 + 11) % 1024, i[1], 1'b0);
    drive(1'b1, 1'b1, 500, 1'b0, 1'b0);
    for (int i = 1; i <= L; i++) begin
      drive(1'b1, 1'b0, (i * 53 + 3) % 1024, 1'b0, 1'b0);
      n_checks++;
      if (a_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL midsof_quiet got %b want 0 (pixel %0d)", a_valid, i);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < L; i++) begin
      drive(1'b1, 1'b0, (i * 29 + 7) % 1024, 1'b0, 1'b0);
      if (a_sof === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_errors++;
      $display("FAIL midsof_resync got out_sof_seen=%b want 1", seen);
    end
  endtask

  task automatic test_reset_midframe();
    int cnt;
    for (int i = 0; i < L + L / 2; i++) drive(1'b1, i == 0, (i * 17) % 1024, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 999, 1'b0, 1'b1);
    n_checks++;
    if (a_valid !== 1'b0 || a_data !== 8'd0 || a_sof !== 1'b0 || b_data !== 8'd0) begin
      n_errors++;
      $display("FAIL midreset got v=%b d=%0d/%0d want 0 0/0", a_valid, a_data, b_data);
    end
    cnt = 0;
    for (int i = 0; i < L + 3; i++) begin
      drive(1'b1, 1'b0, 300, 1'b0, 1'b0);
      if (a_valid === 1'b1) cnt++;
    end
    for (int i = 0; i < 2 * L; i++) begin
      drive(1'b1, i == 0, 300, 1'b0, 1'b0);
      if (a_valid === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != L - 1) begin
      n_errors++;
      $display("FAIL midreset_count got %0d want %0d", cnt, L - 1);
    end
  endtask

  initial begin
    test_reset();
    test_no_sof();
    test_ramp();
    test_flat(40, 8'd40, 8'd2);
    test_flat(1023, 8'd255, 8'd63);
    test_green();
    test_stall();
    test_midline_sof();
    test_reset_midframe();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
